// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchroniser, oversampling bit timer,
// 2-of-3 majority sampling, optional parity, 1 or 2 stop bits, and a small
// show-ahead receive FIFO carrying {frame_err, parity_err, data} per word.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// S_IDLE      | line idle, waiting for first synchronised low sample
// S_START     | timing the start bit; majority 1 means glitch, back to idle
// S_DATA      | shifting in DATA_BITS data bits, LSB first
// S_PAR       | sampling the parity bit (never entered when PARITY == 0)
// S_STOP      | checking STOP_BITS stop bits; word pushed after the last one
// S_WAIT_HIGH | final stop bit was low (break); hold until the line goes high
module uart_rx_cfg #(
  parameter int F_CLK      = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVS        = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int T     = F_CLK / (BAUD * OVS);
  localparam int DIV_W = (T > 1) ? $clog2(T) : 1;
  localparam int TW    = $clog2(OVS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int WW    = DATA_BITS + 2;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(T - 1);
  localparam logic [TW-1:0]    SMP0     = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0]    SMP1     = TW'(OVS / 2);
  localparam logic [TW-1:0]    SMP2     = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0]    TLAST    = TW'(OVS - 1);
  localparam logic [3:0]       DLAST    = 4'(DATA_BITS - 1);
  localparam logic [3:0]       SLAST    = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q, state_d;
  logic                 rxd_s1, rxd_s2;
  logic [DIV_W-1:0]     div_q;
  logic [TW-1:0]        tick_cnt;
  logic [3:0]           bit_cnt;
  logic [1:0]           smp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 fe_q;
  logic                 pe_calc;
  logic                 push_q;
  logic [WW-1:0]        push_word_q;
  logic                 overrun_q;
  logic                 tick, decide, bit_end, maj, last_stop;

  logic [WW-1:0]        mem [FIFO_DEPTH];
  logic [PW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, pop, do_push;
  logic [WW-1:0]        head;

  assign tick    = (state_q != S_IDLE) && (div_q == '0);
  assign decide  = tick && (tick_cnt == SMP2);
  assign bit_end = tick && (tick_cnt == TLAST);
  // third vote is the live sample taken on the deciding tick
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s2) | (smp_q[1] & rxd_s2);

  // two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic and the last-stop-bit decision strobe
  always_comb begin
    state_d   = state_q;
    last_stop = 1'b0;
    case (state_q)
      S_IDLE:      if (!rxd_s2) state_d = S_START;
      S_START: begin
        if (decide && maj)  state_d = S_IDLE;
        else if (bit_end)   state_d = S_DATA;
      end
      S_DATA:      if (bit_end && (bit_cnt == DLAST)) state_d = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:       if (bit_end) state_d = S_STOP;
      S_STOP: begin
        if (decide && (bit_cnt == SLAST)) begin
          last_stop = 1'b1;
          state_d   = maj ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: if (rxd_s2) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // baud divider and in-bit tick / bit counters; held preloaded while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state_q == S_IDLE)  div_q <= DIV_LOAD;
      else if (div_q == '0)   div_q <= DIV_LOAD;
      else                    div_q <= div_q - 1'b1;

      if (state_q == S_IDLE)  tick_cnt <= '0;
      else if (tick)          tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

      if (state_d != state_q) bit_cnt <= '0;
      else if (bit_end)       bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // parity error of the assembled frame, parity taken over data bits only
  always_comb begin
    pe_calc = 1'b0;
    if (PARITY == 1)      pe_calc = par_q ^ (^shift_q);
    else if (PARITY == 2) pe_calc = ~(par_q ^ (^shift_q));
  end

  // majority samples, data shifter, parity/stop capture and word push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      fe_q        <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      if (tick && (tick_cnt == SMP0)) smp_q[0] <= rxd_s2;
      if (tick && (tick_cnt == SMP1)) smp_q[1] <= rxd_s2;
      if (decide && (state_q == S_DATA)) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
      if (decide && (state_q == S_PAR))  par_q <= maj;
      if (state_q == S_START)                              fe_q <= 1'b0;
      else if (decide && (state_q == S_STOP) && !maj)      fe_q <= 1'b1;
      push_q <= last_stop;
      if (last_stop) push_word_q <= {fe_q | ~maj, pe_calc, shift_q};
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rx_valid = !empty;
  assign pop     = rx_valid && rx_ready;
  // a full FIFO still accepts the word when the head leaves in the same cycle
  assign do_push = push_q && (!full || pop);

  // FIFO storage; contents are only visible once rx_valid says so
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_word_q;
  end

  // FIFO pointers and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      overrun_q <= push_q && full && !pop;
    end
  end

  assign head       = mem[rd_ptr[PW-1:0]];
  assign rx_data    = rx_valid ? head[DATA_BITS-1:0] : '0;
  assign parity_err = rx_valid & head[DATA_BITS];
  assign frame_err  = rx_valid & head[DATA_BITS+1];
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
